currctrl_debug_capture: RTL
===========================

// Module: currctrl_debug_capture
// PURPOSE
//  Trigger-based capture writer for the current-control debug RAM.
//  - Accepts a stream of 32-bit controller debug samples.
//  - Writes them into the 512x32 dual-port debug RAM through the RAM's second Avalon-MM port.
//  - Uses a circular buffer with a programmable pre-trigger depth.
//  - Reports where the capture starts, so the Nios/host can read it back over the first port.
//  - Sits between the current-control loop and the debug RAM in the CurrCTRL subsystem.
// PARAMETERS
//  ADDR_W  9   RAM word-address width; DEPTH = 2**ADDR_W (512).
//  DATA_W  32  Sample and RAM word width.
// PORTS
//  clk             in   1       Single clock; same clock as the RAM's second port.
//  reset_n         in   1       Reset: synchronous, active-low.
//  arm             in   1       Pulse: start a new capture (any state).
//  abort           in   1       Pulse: return to IDLE; done stays cleared.
//  pre_cnt         in   ADDR_W  Pre-trigger sample count; sampled on arm.
//  trig_in         in   1       Trigger qualifier; evaluated only with sample_valid.
//  sample_valid    in   1       Sample strobe (no backpressure).
//  sample_data     in   DATA_W  Sample word.
//  ram_address     out  ADDR_W  To RAM port-2 address.
//  ram_writedata   out  DATA_W  To RAM port-2 writedata.
//  ram_byteenable  out  4       Constant 4'hF.
//  ram_chipselect  out  1       Equal to ram_write.
//  ram_write       out  1       One-cycle write strobe.
//  ram_clken       out  1       Constant 1.
//  busy            out  1       State is not IDLE and not DONE.
//  triggered       out  1       Trigger accepted for the current capture.
//  done            out  1       Capture complete; held until the next arm or abort.
//  trig_addr       out  ADDR_W  RAM address holding the trigger sample.
//  start_addr      out  ADDR_W  Oldest valid sample address: (trig_addr - pre) mod DEPTH.
// BEHAVIOUR
//  Reset: state=IDLE.
//   - All outputs are 0 except ram_byteenable=4'hF and ram_clken=1.
//   - Write pointer wp=0.
//  Latency: a sample accepted in cycle N appears on the ram_* signals in cycle N+1.
//   - ram_write is high for exactly one cycle per accepted sample.
//   - All outputs are registered.
//  Sample acceptance: a sample is accepted only when sample_valid=1 and state is PRE, WAIT or POST.
//   - Each accepted sample is written at wp, then wp = (wp+1) mod DEPTH. Wrap is silent.
//  arm:
//   - Sets wp=0.
//   - Sets pre = min(pre_cnt, DEPTH-1); latches the clamped value.
//   - Clears triggered/done; sets fill=0.
//   - Next state is PRE, or WAIT if pre==0.
//   - arm also restarts from PRE, WAIT, POST and DONE.
//  States:
//   IDLE  No writes.
//   PRE   Each accepted sample increments fill. When fill reaches pre, go to WAIT.
//         trig_in is ignored in PRE.
//   WAIT  Samples keep overwriting the circular buffer.
//         An accepted sample with trig_in=1 is the trigger sample:
//          - trig_addr = wp; triggered = 1.
//          - post = DEPTH - pre - 1 (samples still to be written after it); go to POST.
//         If post == 0, go straight to DONE.
//   POST  Each accepted sample decrements post. When the last one is written, go to DONE.
//   DONE  done=1; no writes; outputs hold.
//  Simultaneous events:
//   - arm has priority over abort; abort has priority over sample/trigger.
//   - A sample arriving in the same cycle as arm or abort is dropped.
//  The completion sample's write is still issued in the cycle after entry to DONE.
//  Total samples in a completed capture = DEPTH, ordered start_addr..trig_addr+post (mod DEPTH).
//  Arithmetic: all address math is unsigned modulo 2**ADDR_W. Counters are ADDR_W+1 bits, with no overflow.
// CONFIGURATION
//  CURRCTRL_DBG_TIMESTAMP_EN:
//   - Defined: ram_writedata[31:24] = 8-bit sample index since arm.
//     The index increments per accepted sample and wraps at 256.
//     ram_writedata[23:0] = sample_data[23:0].
//   - Undefined: ram_writedata = sample_data unchanged.
// STRUCTURE
//  Shared package currctrl_dbg_pkg holds:
//   - The state enum (IDLE, PRE, WAIT, POST, DONE).
//   - DBG_ADDR_W=9 and DBG_DATA_W=32.
//   - The RAM byteenable constant.
//  One sub-module, currctrl_dbg_wrport, registers ram_address, ram_writedata and ram_write from accept/wp/data.
//  The FSM and counters stay in the top module.
// TESTING
//  1. Reset: hold reset_n=0 for 3 clk with arm=1 -> state IDLE, ram_write=0, done=0, byteenable=4'hF.
//  2. pre_cnt=16, arm, 20 samples then trig_in=1 on sample 20 (data=0x0000_0014):
//     -> trig_addr=20, start_addr=4, done after 516 total writes, last write addr=3.
//  3. pre_cnt=0, arm, trigger on first sample -> trig_addr=0, start_addr=0, exactly 512 writes, done=1.
//  4. pre_cnt=16, trig_in=1 on samples 0..15 then 0 -> no trigger accepted; trig_in=1 on sample 30 -> trig_addr=30.
//  5. Mid-POST abort (after 100 post samples), then arm in the same cycle as sample_valid=1:
//     -> sample dropped, wp=0, first write at addr 0 on the next accepted sample.
//  6. pre_cnt=511 (clamped to 511), trigger at sample 600:
//     -> trig_addr=88, start_addr=89, done immediately after the trigger write.
//     With CURRCTRL_DBG_TIMESTAMP_EN: word at addr 88 has [31:24]=600 mod 256=0x58.

Source files
------------

// File: rtl/currctrl_dbg_pkg.sv
// Shared types and constants for the current-control debug capture writer.
package currctrl_dbg_pkg;

   localparam int unsigned DBG_ADDR_W = 9;
   localparam int unsigned DBG_DATA_W = 32;

   // All RAM writes are full 32-bit words.
   localparam logic [3:0] DBG_RAM_BE = 4'hF;

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StWait,
      StPost,
      StDone
   } dbg_state_e;

endpackage

// File: rtl/currctrl_dbg_wrport.sv
// RAM port-2 write register stage: turns accept/wp/data into registered Avalon-MM signals.
module currctrl_dbg_wrport #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              accept_i,
   input  logic [ADDR_W-1:0] wp_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [ADDR_W-1:0] ram_address_o,
   output logic [DATA_W-1:0] ram_writedata_o,
   output logic              ram_write_o
);

   logic [ADDR_W-1:0] ram_address_d, ram_address_q;
   logic [DATA_W-1:0] ram_writedata_d, ram_writedata_q;
   logic              ram_write_d, ram_write_q;

   // Capture address/data only on an accepted sample; strobe is one cycle per sample.
   always_comb begin
      ram_address_d   = ram_address_q;
      ram_writedata_d = ram_writedata_q;
      ram_write_d     = accept_i;
      if (accept_i) begin
         ram_address_d   = wp_i;
         ram_writedata_d = data_i;
      end
   end

   // Output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ram_address_q   <= '0;
         ram_writedata_q <= '0;
         ram_write_q     <= 1'b0;
      end else begin
         ram_address_q   <= ram_address_d;
         ram_writedata_q <= ram_writedata_d;
         ram_write_q     <= ram_write_d;
      end
   end

   assign ram_address_o   = ram_address_q;
   assign ram_writedata_o = ram_writedata_q;
   assign ram_write_o     = ram_write_q;

endmodule

// File: rtl/currctrl_debug_capture.sv
// Trigger-based circular capture writer for the current-control debug RAM.
// Optional feature macro: CURRCTRL_DBG_TIMESTAMP_EN (puts an 8-bit sample index in [31:24]).
module currctrl_debug_capture
   import currctrl_dbg_pkg::*;
#(
   parameter int unsigned ADDR_W = DBG_ADDR_W,
   parameter int unsigned DATA_W = DBG_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              arm,
   input  logic              abort,
   input  logic [ADDR_W-1:0] pre_cnt,
   input  logic              trig_in,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_writedata,
   output logic [3:0]        ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic              ram_clken,
   output logic              busy,
   output logic              triggered,
   output logic              done,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W-1:0] start_addr
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DepthM1 = (ADDR_W + 1)'(DEPTH - 1);

   dbg_state_e        state_d, state_q;
   logic [ADDR_W-1:0] wp_d, wp_q;
   logic [ADDR_W-1:0] pre_d, pre_q;
   logic [ADDR_W:0]   fill_d, fill_q;
   logic [ADDR_W:0]   post_d, post_q;
   logic [ADDR_W-1:0] trig_addr_d, trig_addr_q;
   logic [ADDR_W-1:0] start_addr_d, start_addr_q;
   logic              triggered_d, triggered_q;
   logic              busy_d, busy_q;
   logic              done_d, done_q;
   logic              accept;
   logic [DATA_W-1:0] wr_data;
`ifdef CURRCTRL_DBG_TIMESTAMP_EN
   logic [7:0]        ts_d, ts_q;
`endif

   // Samples are taken only while capturing; arm/abort in the same cycle drop the sample.
   assign accept = sample_valid && !arm && !abort &&
                   ((state_q == StPre) || (state_q == StWait) || (state_q == StPost));

   // Next-state and counter logic; priority arm > abort > sample.
   always_comb begin
      state_d      = state_q;
      wp_d         = wp_q;
      pre_d        = pre_q;
      fill_d       = fill_q;
      post_d       = post_q;
      trig_addr_d  = trig_addr_q;
      start_addr_d = start_addr_q;
      triggered_d  = triggered_q;
`ifdef CURRCTRL_DBG_TIMESTAMP_EN
      ts_d         = ts_q;
`endif
      if (arm) begin
         wp_d         = '0;
         // An ADDR_W-bit count never exceeds DEPTH-1, so the clamp is implicit.
         pre_d        = pre_cnt;
         fill_d       = '0;
         post_d       = '0;
         trig_addr_d  = '0;
         start_addr_d = '0;
         triggered_d  = 1'b0;
`ifdef CURRCTRL_DBG_TIMESTAMP_EN
         ts_d         = '0;
`endif
         state_d      = (pre_cnt == '0) ? StWait : StPre;
      end else if (abort) begin
         state_d = StIdle;
      end else if (accept) begin
         wp_d = wp_q + 1'b1;
`ifdef CURRCTRL_DBG_TIMESTAMP_EN
         ts_d = ts_q + 8'd1;
`endif
         case (state_q)
            StPre: begin
               fill_d = fill_q + 1'b1;
               if (fill_d == {1'b0, pre_q}) state_d = StWait;
            end
            StWait: begin
               if (trig_in) begin
                  trig_addr_d  = wp_q;
                  start_addr_d = wp_q - pre_q;
                  triggered_d  = 1'b1;
                  post_d       = DepthM1 - {1'b0, pre_q};
                  state_d      = (post_d == '0) ? StDone : StPost;
               end
            end
            StPost: begin
               post_d = post_q - 1'b1;
               if (post_d == '0) state_d = StDone;
            end
            default: ;
         endcase
      end
      busy_d = (state_d == StPre) || (state_d == StWait) || (state_d == StPost);
      done_d = (state_d == StDone);
   end

   // FSM, counters and status registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         wp_q         <= '0;
         pre_q        <= '0;
         fill_q       <= '0;
         post_q       <= '0;
         trig_addr_q  <= '0;
         start_addr_q <= '0;
         triggered_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef CURRCTRL_DBG_TIMESTAMP_EN
         ts_q         <= '0;
`endif
      end else begin
         state_q      <= state_d;
         wp_q         <= wp_d;
         pre_q        <= pre_d;
         fill_q       <= fill_d;
         post_q       <= post_d;
         trig_addr_q  <= trig_addr_d;
         start_addr_q <= start_addr_d;
         triggered_q  <= triggered_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef CURRCTRL_DBG_TIMESTAMP_EN
         ts_q         <= ts_d;
`endif
      end
   end

`ifdef CURRCTRL_DBG_TIMESTAMP_EN
   assign wr_data = {ts_q, sample_data[DATA_W-9:0]};
`else
   assign wr_data = sample_data;
`endif

   currctrl_dbg_wrport #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_wrport (
      .clk            (clk),
      .reset_n        (reset_n),
      .accept_i       (accept),
      .wp_i           (wp_q),
      .data_i         (wr_data),
      .ram_address_o  (ram_address),
      .ram_writedata_o(ram_writedata),
      .ram_write_o    (ram_write)
   );

   assign ram_byteenable = DBG_RAM_BE;
   assign ram_chipselect = ram_write;
   assign ram_clken      = 1'b1;
   assign busy           = busy_q;
   assign triggered      = triggered_q;
   assign done           = done_q;
   assign trig_addr      = trig_addr_q;
   assign start_addr     = start_addr_q;

endmodule
